// File: rtl/rgb_to_hsl.sv
// rgb_to_hsl: iterative RGB to HSL converter (hue circle 192) with a valid/ready handshake on both sides.
// Optional macro RGB2HSL_GRAY_THRESH_EN treats near-gray pixels (delta < 4) as achromatic.
module rgb_to_hsl #(
    parameter int IO_W  = 10,
    parameter int INT_W = 8
) (
    input  logic            clock,
    input  logic            iReset_n,
    input  logic            iValid,
    output logic            oReady,
    input  logic [IO_W-1:0] iRed,
    input  logic [IO_W-1:0] iGreen,
    input  logic [IO_W-1:0] iBlue,
    output logic            oValid,
    input  logic            iReady,
    output logic [IO_W-1:0] oHue,
    output logic [IO_W-1:0] oSaturation,
    output logic [IO_W-1:0] oLightness
);
    localparam int W  = INT_W;
    localparam int CW = $clog2(W);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] DIVIDE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [W-1:0] MAXV     = '1;
    localparam logic [W:0]   TWO_MAX  = {MAXV, 1'b0};
    localparam logic [W-1:0] HUE_G    = W'(64);
    localparam logic [W-1:0] HUE_B    = W'(128);
    localparam logic [W-1:0] HUE_WRAP = W'(192);

    logic [1:0]    state_q, state_d;
    logic          run_q, run_d;
    logic [W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  l_q, l_d, base_q, base_d;
    logic          neg_q, neg_d;
    logic [W:0]    s_rem_q, s_rem_d, s_den_q, s_den_d;
    logic [W:0]    h_rem_q, h_rem_d, h_den_q, h_den_d;
    logic [W-1:0]  s_num_q, s_num_d, h_num_q, h_num_d;
    logic [W-1:0]  h_out_q, h_out_d, s_out_q, s_out_d, l_out_q, l_out_d;

    logic           r_max, g_max, neg, achro, s_ge, h_ge;
    logic [W-1:0]   mx, mn, dl, x, y, ad, base, lv, s_quo, h_quo, h_raw, h_fin;
    logic [W:0]     sum, den, s_rem_n, h_rem_n;
    logic [W+1:0]   s_sh, h_sh;
    logic [2*W-1:0] s_num, h_num;
    logic           unused_lsb;

    assign unused_lsb = ^{iRed[IO_W-W-1:0], iGreen[IO_W-W-1:0], iBlue[IO_W-W-1:0]};

    // Pixel analysis used in SETUP; ties resolve toward red, then green.
    always_comb begin
        r_max = r_q >= g_q && r_q >= b_q;
        g_max = !r_max && g_q >= b_q;
        mx    = r_max ? r_q : g_max ? g_q : b_q;
        mn    = (r_q <= g_q && r_q <= b_q) ? r_q : (g_q <= b_q) ? g_q : b_q;
        dl    = mx - mn;
        sum   = {1'b0, mx} + {1'b0, mn};
        lv    = sum[W:1];
        den   = lv[W-1] ? TWO_MAX - sum : sum;
        x     = r_max ? g_q : g_max ? b_q : r_q;
        y     = r_max ? b_q : g_max ? r_q : g_q;
        neg   = x < y;
        ad    = neg ? y - x : x - y;
        base  = r_max ? (neg ? HUE_WRAP : '0) : g_max ? HUE_G : HUE_B;
        s_num = {{W{1'b0}}, dl} * {{W{1'b0}}, MAXV};
        h_num = {{W{1'b0}}, ad} << 5;
`ifdef RGB2HSL_GRAY_THRESH_EN
        achro = dl < W'(4);
`else
        achro = dl == '0;
`endif
    end

    // One restoring step per divider; quotient bits shift in behind the numerator bits.
    always_comb begin
        s_sh    = {s_rem_q, s_num_q[W-1]};
        s_ge    = s_sh >= {1'b0, s_den_q};
        s_rem_n = s_ge ? (W+1)'(s_sh - {1'b0, s_den_q}) : s_sh[W:0];
        s_quo   = {s_num_q[W-2:0], s_ge};
        h_sh    = {h_rem_q, h_num_q[W-1]};
        h_ge    = h_sh >= {1'b0, h_den_q};
        h_rem_n = h_ge ? (W+1)'(h_sh - {1'b0, h_den_q}) : h_sh[W:0];
        h_quo   = {h_num_q[W-2:0], h_ge};
        h_raw   = neg_q ? base_q - h_quo : base_q + h_quo;
        h_fin   = (h_raw == HUE_WRAP) ? '0 : h_raw;
    end

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        base_d  = base_q;
        neg_d   = neg_q;
        s_rem_d = s_rem_q;
        s_den_d = s_den_q;
        s_num_d = s_num_q;
        h_rem_d = h_rem_q;
        h_den_d = h_den_q;
        h_num_d = h_num_q;
        h_out_d = h_out_q;
        s_out_d = s_out_q;
        l_out_d = l_out_q;
        if (state_q == IDLE) begin
            if (iValid && run_q) begin
                r_d     = iRed[IO_W-1 -: W];
                g_d     = iGreen[IO_W-1 -: W];
                b_d     = iBlue[IO_W-1 -: W];
                state_d = SETUP;
            end
        end else if (state_q == SETUP) begin
            if (achro) begin
                h_out_d = '0;
                s_out_d = '0;
                l_out_d = lv;
                state_d = DONE;
            end else begin
                cnt_d   = '0;
                l_d     = lv;
                base_d  = base;
                neg_d   = neg;
                s_rem_d = {1'b0, s_num[2*W-1:W]};
                s_num_d = s_num[W-1:0];
                s_den_d = den;
                h_rem_d = {1'b0, h_num[2*W-1:W]};
                h_num_d = h_num[W-1:0];
                h_den_d = {1'b0, dl};
                state_d = DIVIDE;
            end
        end else if (state_q == DIVIDE) begin
            s_rem_d = s_rem_n;
            s_num_d = s_quo;
            h_rem_d = h_rem_n;
            h_num_d = h_quo;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                h_out_d = h_fin;
                s_out_d = s_quo;
                l_out_d = l_q;
                state_d = DONE;
            end
        end else begin
            state_d = iReady ? IDLE : DONE;
        end
    end

    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            l_q     <= '0;
            base_q  <= '0;
            neg_q   <= 1'b0;
            s_rem_q <= '0;
            s_den_q <= '0;
            s_num_q <= '0;
            h_rem_q <= '0;
            h_den_q <= '0;
            h_num_q <= '0;
            h_out_q <= '0;
            s_out_q <= '0;
            l_out_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            base_q  <= base_d;
            neg_q   <= neg_d;
            s_rem_q <= s_rem_d;
            s_den_q <= s_den_d;
            s_num_q <= s_num_d;
            h_rem_q <= h_rem_d;
            h_den_q <= h_den_d;
            h_num_q <= h_num_d;
            h_out_q <= h_out_d;
            s_out_q <= s_out_d;
            l_out_q <= l_out_d;
        end
    end

    assign oReady      = run_q && state_q == IDLE;
    assign oValid      = state_q == DONE;
    assign oHue        = {h_out_q, {(IO_W-W){1'b0}}};
    assign oSaturation = {s_out_q, {(IO_W-W){1'b0}}};
    assign oLightness  = {l_out_q, {(IO_W-W){1'b0}}};
endmodule

// File: doc/rgb_to_hsl.md
RGB_TO_HSL -- requirements
Module: rgb_to_hsl

Interface
REQ-001 SHALL have parameter IO_W, default 10, pixel component width on all data ports.
REQ-002 SHALL have parameter INT_W, default 8, internal arithmetic precision per component.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port iReset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iValid  input  1  upstream pixel valid.
REQ-006 SHALL have port oReady  output  1  block can accept a pixel.
REQ-007 SHALL have ports iRed, iGreen, iBlue  input  IO_W  RGB components, 0 = none, all-ones = full.
REQ-008 SHALL have port oValid  output  1  HSL result valid.
REQ-009 SHALL have port iReady  input  1  downstream accepts result.
REQ-010 SHALL have ports oHue, oSaturation, oLightness  output  IO_W  HSL result in the same encoding HSLtoRGB consumes.

Function
REQ-011 SHALL accept a pixel on a rising edge where iValid=1 and oReady=1; iValid SHALL be ignored while oReady=0.
REQ-012 SHALL truncate captured inputs to INT_W bits by dropping the 2 LSBs.
REQ-013 SHALL implement FSM IDLE -> SETUP -> DIVIDE -> DONE -> IDLE; oReady=1 only in IDLE, oValid=1 only in DONE.
REQ-014 SETUP (1 cycle) SHALL compute max, min, delta=max-min, sum=max+min (9 bit), and L=sum>>1.
REQ-015 Achromatic pixel (delta=0) SHALL go SETUP -> DONE with H=0, S=0, L per REQ-014; result on the 2nd edge after accept.
REQ-016 Chromatic pixel SHALL spend exactly 8 cycles in DIVIDE, running two restoring dividers in parallel, one quotient bit per cycle; oValid SHALL rise on the 10th edge after accept.
REQ-017 Saturation SHALL be S=floor(delta*255/den), where den=sum if L<128, else den=510-sum; result range 0..255, no clamp required.
REQ-018 Hue SHALL use a full circle of 192 (sextant 32), with q=floor(|diff|*32/delta).
REQ-019 Hue by maximum, tie priority R>G>B:
 - max=R: H = (G>=B) ? q : 192-q.
 - max=G: H = (B>=R) ? 64+q : 64-q.
 - max=B: H = (R>=G) ? 128+q : 128-q.
REQ-020 Hue value 192 SHALL wrap to 0.
REQ-021 Outputs SHALL be {value[INT_W-1:0], 2'b00}.
REQ-022 In DONE, outputs and oValid SHALL hold stable until an edge with iReady=1; that edge SHALL return the FSM to IDLE.
REQ-023 Output data registers SHALL retain the last result after the handshake.
REQ-024 Peak throughput SHALL be one chromatic pixel per 11 cycles.

Reset
REQ-025 iReset_n=0 SHALL immediately force IDLE, oValid=0, oReady=0, and oHue=oSaturation=oLightness=0, regardless of the current state.
REQ-026 oReady SHALL rise on the first rising edge after iReset_n deasserts.
REQ-027 A transaction in flight at reset SHALL be discarded without producing any output.

Configuration
REQ-028 Macro RGB2HSL_GRAY_THRESH_EN: when defined, pixels with delta<4 SHALL be treated as achromatic per REQ-015 (H=0, S=0, 2-cycle path).
REQ-029 When the macro is undefined, only delta=0 SHALL be achromatic.

Verification
REQ-030 Pure red (iRed=10'h3FC, iGreen=iBlue=0) -> oHue=0, oSaturation=10'h3FC, oLightness=10'h1FC; oValid on the 10th edge after accept.
REQ-031 Gray (all inputs 10'h200) -> oHue=0, oSaturation=0, oLightness=10'h200; oValid on the 2nd edge after accept.
REQ-032 Pure green, pure blue, and magenta (R=B=10'h3FC, G=0) -> oHue=256, 512, and 640 respectively; oSaturation=10'h3FC for all three.
REQ-033 R=520, G=B=512: with RGB2HSL_GRAY_THRESH_EN -> H=0, S=0, L=516; without the macro -> H=0, S=8, L=516.
REQ-034 iReady held 0 for 20 cycles in DONE -> outputs stable, oReady=0, iValid pulses ignored; iReady=1 -> IDLE the next cycle.
REQ-035 iReset_n pulsed low in cycle 4 of DIVIDE -> all outputs 0 at once; the next pixel converts correctly with nominal latency.
